// File: rtl/alu_ctrl_idex.sv
`default_nettype none
// ============================================================================
// alu_ctrl_idex : RV32I ALU-control decode with ID/EX pipeline register
// Rev 1.0 - initial release
// ============================================================================
module alu_ctrl_idex #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      InstrD,
  input  logic             ValidD,
  input  logic             StallE,
  input  logic             FlushE,
  output logic [3:0]       OpCodeE,
  output logic [1:0]       ALUSrcAE,
  output logic             ALUSrcBE,
  output logic             BranchE,
  output logic [2:0]       Funct3E,
  output logic             ValidE,
  output logic             IllegalE,
  output logic [CNT_W-1:0] IllegalCnt
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alt;
  logic [3:0] arith_op;
  logic [3:0] dec_op;
  logic [1:0] dec_src_a;
  logic       dec_src_b;
  logic       dec_branch;
  logic       dec_illegal;
  logic       load_en;

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign alt    = InstrD[30];

  // Shared R/I arithmetic map; add/sub selection is qualified per opcode below.
  always_comb begin
    arith_op = OP_ADD;
    case (funct3)
      3'b000:  arith_op = OP_ADD;
      3'b001:  arith_op = OP_SLL;
      3'b010:  arith_op = OP_SLT;
      3'b011:  arith_op = OP_SLTU;
      3'b100:  arith_op = OP_XOR;
      3'b101:  arith_op = alt ? OP_SRA : OP_SRL;
      3'b110:  arith_op = OP_OR;
      default: arith_op = OP_AND;
    endcase
  end

  always_comb begin
    dec_op      = OP_ADD;
    dec_src_a   = 2'b00;
    dec_src_b   = 1'b0;
    dec_branch  = 1'b0;
    dec_illegal = 1'b0;
    case (opcode)
      OPC_R: begin
        dec_op = (funct3 == 3'b000 && alt) ? OP_SUB : arith_op;
      end
      OPC_I: begin
        dec_op    = arith_op;
        dec_src_b = 1'b1;
      end
      OPC_LOAD, OPC_STORE, OPC_JALR: begin
        dec_src_b = 1'b1;
      end
      OPC_LUI: begin
        dec_src_a = 2'b10;
        dec_src_b = 1'b1;
      end
      OPC_AUIPC, OPC_JAL: begin
        dec_src_a = 2'b01;
        dec_src_b = 1'b1;
      end
      OPC_BRANCH: begin
        case (funct3[2:1])
          2'b00:   begin dec_op = OP_SUB;  dec_branch = 1'b1; end
          2'b10:   begin dec_op = OP_SLT;  dec_branch = 1'b1; end
          2'b11:   begin dec_op = OP_SLTU; dec_branch = 1'b1; end
          default: dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  assign load_en = !FlushE && !StallE && ValidD;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      OpCodeE  <= OP_ADD;
      ALUSrcAE <= 2'b00;
      ALUSrcBE <= 1'b0;
      BranchE  <= 1'b0;
      Funct3E  <= 3'b000;
      ValidE   <= 1'b0;
      IllegalE <= 1'b0;
    end else if (FlushE || (!StallE && !ValidD)) begin
      OpCodeE  <= OP_ADD;
      ALUSrcAE <= 2'b00;
      ALUSrcBE <= 1'b0;
      BranchE  <= 1'b0;
      Funct3E  <= 3'b000;
      ValidE   <= 1'b0;
      IllegalE <= 1'b0;
    end else if (!StallE) begin
      OpCodeE  <= dec_op;
      ALUSrcAE <= dec_src_a;
      ALUSrcBE <= dec_src_b;
      BranchE  <= dec_branch;
      Funct3E  <= funct3;
      ValidE   <= 1'b1;
      IllegalE <= dec_illegal;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      IllegalCnt <= '0;
    end else if (load_en && dec_illegal && IllegalCnt != CNT_MAX) begin
      IllegalCnt <= IllegalCnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_idex.sv
`default_nettype none
// ============================================================================
// tb_alu_ctrl_idex : self-checking bench for alu_ctrl_idex
// Rev 1.0 - initial release
// ============================================================================
module tb_alu_ctrl_idex;

  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic [31:0]      InstrD;
  logic             ValidD;
  logic             StallE;
  logic             FlushE;
  logic [3:0]       OpCodeE;
  logic [1:0]       ALUSrcAE;
  logic             ALUSrcBE;
  logic             BranchE;
  logic [2:0]       Funct3E;
  logic             ValidE;
  logic             IllegalE;
  logic [CNT_W-1:0] IllegalCnt;

  int total;
  int passed;

  alu_ctrl_idex #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .InstrD(InstrD), .ValidD(ValidD),
    .StallE(StallE), .FlushE(FlushE), .OpCodeE(OpCodeE),
    .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE), .BranchE(BranchE),
    .Funct3E(Funct3E), .ValidE(ValidE), .IllegalE(IllegalE),
    .IllegalCnt(IllegalCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected architectural state of the E stage
  typedef struct packed {
    logic [3:0] op;
    logic [1:0] sa;
    logic       sb;
    logic       br;
    logic [2:0] f3;
    logic       v;
    logic       ill;
  } stage_t;

  stage_t exp_st;
  int     exp_cnt;

  function automatic logic [20:0] dut_vec();
    return {OpCodeE, ALUSrcAE, ALUSrcBE, BranchE, Funct3E, ValidE, IllegalE, IllegalCnt};
  endfunction

  function automatic logic [20:0] exp_vec();
    logic [7:0] c;
    c = 8'(exp_cnt);
    return {exp_st, c};
  endfunction

  // Reference decode from the instruction-set rules
  function automatic stage_t ref_decode(input logic [31:0] ins);
    logic [3:0] arith [8];
    stage_t d;
    logic [6:0] opc;
    logic [2:0] f3;
    arith = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd2, 4'd6, 4'd3, 4'd4};
    opc = ins[6:0];
    f3  = ins[14:12];
    d = '0;
    d.v  = 1'b1;
    d.f3 = f3;
    if (opc == 7'h33 || opc == 7'h13) begin
      d.op = arith[f3];
      if (f3 == 3'd5 && ins[30]) d.op = 4'd7;
      if (f3 == 3'd0 && ins[30] && opc == 7'h33) d.op = 4'd1;
      d.sb = (opc == 7'h13);
    end else if (opc == 7'h03 || opc == 7'h23 || opc == 7'h67) begin
      d.sb = 1'b1;
    end else if (opc == 7'h37) begin
      d.sa = 2'd2; d.sb = 1'b1;
    end else if (opc == 7'h17 || opc == 7'h6F) begin
      d.sa = 2'd1; d.sb = 1'b1;
    end else if (opc == 7'h63 && f3 != 3'd2 && f3 != 3'd3) begin
      d.br = 1'b1;
      d.op = (f3 < 3'd4) ? 4'd1 : (f3 < 3'd6) ? 4'd8 : 4'd9;
    end else begin
      d.ill = 1'b1;
    end
    return d;
  endfunction

  task automatic model_edge();
    stage_t d;
    d = ref_decode(InstrD);
    if (FlushE) exp_st = '0;
    else if (StallE) exp_st = exp_st;
    else if (!ValidD) exp_st = '0;
    else begin
      exp_st = d;
      if (d.ill && exp_cnt < CMAX) exp_cnt++;
    end
  endtask

  // One clock: model follows the edge, outputs sampled 1ns later
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ValidD = 1'b1; InstrD = 32'hFFFF_FFFF; StallE = 1'b0; FlushE = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    ValidD = 1'b0; InstrD = '0;
    exp_st = '0; exp_cnt = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ValidD = 1'b1; InstrD = 32'hFFFF_FFFF; StallE = 1'b0; FlushE = 1'b0;
    @(posedge clk); #1;
    total++;
    if (dut_vec() !== 21'd0) $display("FAIL reset_hold got=%h exp=%h", dut_vec(), 21'd0);
    else passed++;
    do_reset();
    #1;
    total++;
    if (dut_vec() !== 21'd0) $display("FAIL reset_release got=%h exp=%h", dut_vec(), 21'd0);
    else passed++;
  endtask

  task automatic test_directed();
    do_reset();
    ValidD = 1'b1; InstrD = 32'h402081B3;
    step();
    total++;
    if (dut_vec() !== {4'd1, 2'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 8'd0})
      $display("FAIL dir_sub got=%h", dut_vec());
    else passed++;
    InstrD = 32'h40335293;
    step();
    total++;
    if (dut_vec() !== {4'd7, 2'd0, 1'b1, 1'b0, 3'd5, 1'b1, 1'b0, 8'd0})
      $display("FAIL dir_srai got=%h", dut_vec());
    else passed++;
    InstrD = 32'h0020E463;
    step();
    total++;
    if (dut_vec() !== {4'd9, 2'd0, 1'b0, 1'b1, 3'd6, 1'b1, 1'b0, 8'd0})
      $display("FAIL dir_bltu got=%h", dut_vec());
    else passed++;
    ValidD = 1'b0;
    step();
    total++;
    if (dut_vec() !== 21'd0) $display("FAIL dir_bubble got=%h exp=0", dut_vec());
    else passed++;
  endtask

  task automatic test_stall_flush();
    do_reset();
    ValidD = 1'b1; InstrD = 32'h402081B3;
    step();
    StallE = 1'b1; InstrD = 32'h40335293;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (OpCodeE !== 4'd1 || ValidE !== 1'b1)
        $display("FAIL stall_hold cyc=%0d op=%h v=%b exp op=1 v=1", i, OpCodeE, ValidE);
      else passed++;
    end
    FlushE = 1'b1;
    step();
    total++;
    if (ValidE !== 1'b0 || OpCodeE !== 4'd0 || dut_vec() !== exp_vec())
      $display("FAIL flush_over_stall got=%h exp=%h", dut_vec(), exp_vec());
    else passed++;
    StallE = 1'b0; FlushE = 1'b0;
  endtask

  task automatic test_illegal_sat();
    do_reset();
    ValidD = 1'b1; InstrD = 32'hFFFF_FFFF;
    StallE = 1'b1;
    repeat (20) step();
    StallE = 1'b0; FlushE = 1'b1;
    repeat (5) step();
    total++;
    if (IllegalCnt !== 8'd0) $display("FAIL ill_stall_flush got=%0d exp=0", IllegalCnt);
    else passed++;
    FlushE = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      total++;
      if (dut_vec() !== exp_vec())
        $display("FAIL ill_stream cyc=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      else passed++;
    end
    total++;
    if (IllegalCnt !== 8'd255 || IllegalE !== 1'b1)
      $display("FAIL ill_saturate cnt=%0d ill=%b exp cnt=255 ill=1", IllegalCnt, IllegalE);
    else passed++;
  endtask

  task automatic test_async_reset();
    do_reset();
    ValidD = 1'b1; InstrD = 32'hFFFF_FFFF;
    repeat (5) step();
    InstrD = 32'h402081B3;
    step();
    total++;
    if (ValidE !== 1'b1 || IllegalCnt !== 8'd5)
      $display("FAIL areset_pre v=%b cnt=%0d exp v=1 cnt=5", ValidE, IllegalCnt);
    else passed++;
    StallE = 1'b1;
    #2 reset = 1'b1;
    #1;
    total++;
    if (dut_vec() !== 21'd0) $display("FAIL areset_async got=%h exp=0", dut_vec());
    else passed++;
    #1 reset = 1'b0;
    exp_st = '0; exp_cnt = 0;
    StallE = 1'b0; InstrD = 32'h40335293;
    step();
    total++;
    if (dut_vec() !== {4'd7, 2'd0, 1'b1, 1'b0, 3'd5, 1'b1, 1'b0, 8'd0})
      $display("FAIL areset_next_load got=%h", dut_vec());
    else passed++;
  endtask

  task automatic test_random();
    logic [6:0] opcs [11];
    logic [31:0] ins;
    opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h67, 7'h37, 7'h17, 7'h6F, 7'h63, 7'h63, 7'h7F};
    do_reset();
    for (int i = 0; i < 600; i++) begin
      ins = $urandom;
      if ($urandom_range(0, 9) != 0) ins[6:0] = opcs[$urandom_range(0, 10)];
      InstrD = ins;
      ValidD = ($urandom_range(0, 3) != 0);
      StallE = ($urandom_range(0, 4) == 0);
      FlushE = ($urandom_range(0, 9) == 0);
      step();
      total++;
      if (dut_vec() !== exp_vec())
        $display("FAIL random cyc=%0d ins=%h got=%h exp=%h", i, ins, dut_vec(), exp_vec());
      else passed++;
    end
  endtask

  initial begin
    total = 0; passed = 0;
    exp_st = '0; exp_cnt = 0;
    reset = 1'b0; InstrD = '0; ValidD = 1'b0; StallE = 1'b0; FlushE = 1'b0;
    #2;
    test_reset();
    test_directed();
    test_stall_flush();
    test_illegal_sat();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
